// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory program loader: memory
// geometry, the loader state encoding and the big-endian byte-lane shifts.
// The CHECK state exists only when IMEM_LOADER_CHECKSUM_EN is defined.
package imem_pkg;

    localparam int DEPTH  = 32;
    localparam int ADDR_W = $clog2(DEPTH);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        CHECK  = 2'd2,
        FINISH = 2'd3
    } loader_state_t;
`else
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        FINISH = 2'd3
    } loader_state_t;
`endif

    // The first byte of a word is the most significant one.
    localparam logic [4:0] LANE0_SHIFT = 5'd24;
    localparam logic [4:0] LANE1_SHIFT = 5'd16;
    localparam logic [4:0] LANE2_SHIFT = 5'd8;
    localparam logic [4:0] LANE3_SHIFT = 5'd0;

    function automatic logic [4:0] lane_shift(input logic [1:0] lane);
        logic [4:0] shift;
        case (lane)
            2'd0:    shift = LANE0_SHIFT;
            2'd1:    shift = LANE1_SHIFT;
            2'd2:    shift = LANE2_SHIFT;
            default: shift = LANE3_SHIFT;
        endcase
        return shift;
    endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// byte_packer: collects four accepted bytes into one big-endian 32-bit word
// and pulses word_valid for the cycle after the fourth byte is taken.
module byte_packer
    import imem_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_xfer,
    input  logic [7:0]  byte_in,
    output logic        last_lane,
    output logic [31:0] word_out,
    output logic        word_valid
);

    logic [1:0]  byte_count;
    logic [31:0] partial;

    assign last_lane = (byte_count == 2'd3);

    // Merge each byte into its lane; the fourth byte publishes the word and restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_count <= 2'd0;
            partial    <= 32'd0;
            word_out   <= 32'd0;
            word_valid <= 1'b0;
        end else if (clear) begin
            byte_count <= 2'd0;
            partial    <= 32'd0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (byte_xfer) begin
                byte_count <= byte_count + 2'd1;
                if (last_lane) begin
                    word_out   <= partial | ({24'd0, byte_in} << lane_shift(byte_count));
                    partial    <= 32'd0;
                    word_valid <= 1'b1;
                end else begin
                    partial <= partial | ({24'd0, byte_in} << lane_shift(byte_count));
                end
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: streams bytes into instruction words and writes them to
// consecutive word addresses from 0 while holding the CPU off.
// Optional checksum stage: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int DEPTH  = imem_pkg::DEPTH,
    parameter int ADDR_W = imem_pkg::ADDR_W
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              Start,
    input  logic [ADDR_W:0]   Word_count,
    input  logic [7:0]        Byte_in,
    input  logic              Byte_valid,
    output logic              Byte_ready,
    output logic              Write_enable,
    output logic [31:0]       Write_address,
    output logic [31:0]       Write_data,
    output logic              Cpu_hold,
    output logic              Done,
    output logic              Error
);
    import imem_pkg::*;

    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

    loader_state_t     state, state_next;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   words_packed;
    logic [ADDR_W-1:0] word_index;
    logic              done_next, error_next, hold_next;
    logic              start_ok, start_bad, byte_xfer, last_write;
    logic              last_lane, pk_word_valid;
    logic [31:0]       pk_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0]       checksum;
`endif

    assign start_ok   = (state == IDLE) && Start && (Word_count != '0) && (Word_count <= DEPTH_W);
    assign start_bad  = (state == IDLE) && Start && ((Word_count == '0) || (Word_count > DEPTH_W));
    assign byte_xfer  = Byte_valid && Byte_ready;
    assign last_write = Write_enable && ({1'b0, word_index} == (count_q - 1'b1));

    assign Write_address = {{(32-ADDR_W){1'b0}}, word_index};
    assign Write_data    = pk_word;

    byte_packer u_packer (
        .clk        (Clock),
        .rst_n      (Reset_n),
        .clear      (start_ok),
        .byte_xfer  (byte_xfer),
        .byte_in    (Byte_in),
        .last_lane  (last_lane),
        .word_out   (pk_word),
        .word_valid (pk_word_valid)
    );

    // Accept bytes only while words (or the checksum) remain outstanding.
    always_comb begin
        Byte_ready = 1'b0;
        case (state)
            LOAD:    Byte_ready = (words_packed != count_q);
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHECK:   Byte_ready = !pk_word_valid;
`endif
            default: Byte_ready = 1'b0;
        endcase
    end

    // Next state and next values of the registered status flags.
    always_comb begin
        state_next = state;
        done_next  = Done;
        error_next = Error;
        hold_next  = Cpu_hold;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    state_next = LOAD;
                    done_next  = 1'b0;
                    error_next = 1'b0;
                    hold_next  = 1'b1;
                end else if (start_bad) begin
                    error_next = 1'b1;
                end
            end
            LOAD: begin
                if (last_write) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_next = CHECK;
`else
                    state_next = FINISH;
`endif
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHECK: begin
                if (pk_word_valid) begin
                    if (pk_word == checksum) begin
                        state_next = FINISH;
                    end else begin
                        state_next = IDLE;
                        error_next = 1'b1;
                        done_next  = 1'b0;
                        hold_next  = 1'b0;
                    end
                end
            end
`endif
            FINISH: begin
                state_next = IDLE;
                done_next  = 1'b1;
                hold_next  = 1'b0;
            end
            default: state_next = IDLE;
        endcase
    end

    // State and status flag registers.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= IDLE;
            Done     <= 1'b0;
            Error    <= 1'b0;
            Cpu_hold <= 1'b0;
        end else begin
            state    <= state_next;
            Done     <= done_next;
            Error    <= error_next;
            Cpu_hold <= hold_next;
        end
    end

    // Write strobe one cycle after a word completes; the index advances as that write retires.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            Write_enable <= 1'b0;
            count_q      <= '0;
            words_packed <= '0;
            word_index   <= '0;
        end else begin
            Write_enable <= (state == LOAD) && byte_xfer && last_lane;
            if (start_ok) begin
                count_q      <= Word_count;
                words_packed <= '0;
                word_index   <= '0;
            end else begin
                if ((state == LOAD) && byte_xfer && last_lane) begin
                    words_packed <= words_packed + 1'b1;
                end
                if (Write_enable && !last_write) begin
                    word_index <= word_index + 1'b1;
                end
            end
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Running sum of every word written during this load.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            checksum <= 32'd0;
        end else if (start_ok) begin
            checksum <= 32'd0;
        end else if (Write_enable) begin
            checksum <= checksum + Write_data;
        end
    end
`endif

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader for the single-cycle MIPS instruction memory: the write-side counterpart to the combinational, word-indexed instruction read port. It accepts a byte stream over a valid/ready handshake, packs bytes big-endian into 32-bit instruction words, and writes them to consecutive word addresses starting at 0. While loading, it holds the CPU off through `Cpu_hold`. This lets a program be loaded at run time instead of from a file at elaboration.

## Interface
- `DEPTH`, 32: number of instruction words in memory.
- `ADDR_W`, 5: word-index width, equal to clog2(`DEPTH`).
- `Clock`  in  1  sole clock; all state updates on the rising edge.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `Start`  in  1  level-sampled request to begin a load; honoured only in IDLE.
- `Word_count`  in  ADDR_W+1  number of words to load; latched when `Start` is accepted.
- `Byte_in`  in  8  stream data byte.
- `Byte_valid`  in  1  `Byte_in` is valid.
- `Byte_ready`  out  1  loader can accept a byte.
- `Write_enable`  out  1  one-cycle write strobe to instruction memory.
- `Write_address`  out  32  word index (not byte address); upper bits zero.
- `Write_data`  out  32  packed instruction word.
- `Cpu_hold`  out  1  high while a load is in progress.
- `Done`  out  1  load completed; held until the next accepted `Start`.
- `Error`  out  1  sticky error flag; cleared by the next accepted `Start`.

## Operation
- States: IDLE, LOAD, FINISH. CHECK exists only with the macro (see Configuration).
- Reset: state IDLE; every output 0; byte counter, word counter and partial word cleared.
- IDLE:
  - `Start`=1 with 1 ≤ `Word_count` ≤ `DEPTH` → LOAD. Latch the count, word index := 0, clear `Done` and `Error`.
  - `Start`=1 with `Word_count`=0 or `Word_count` > `DEPTH` → stay in IDLE, set `Error`=1, leave `Done` unchanged.
- LOAD:
  - `Cpu_hold`=1.
  - `Byte_ready`=1 until the final byte of the final word has been accepted, then 0.
  - A byte transfers only on an edge where `Byte_valid`&&`Byte_ready`.
  - Packing: the first byte goes to bits 31:24, the fourth to bits 7:0.
  - A 2-bit byte counter wraps 3→0 on each completed word.
- Word write:
  - Completing a word at edge N drives `Write_enable`=1 for exactly the cycle after edge N.
  - In that cycle, `Write_address` = current word index and `Write_data` = packed word.
  - The word index increments at edge N+1.
  - Bytes of the next word may be accepted during the write cycle (no bubble).
- After the write of the last word → FINISH for one cycle, then IDLE with `Done`=1 and `Cpu_hold`=0.
- `Start` is ignored outside IDLE.
- `Byte_valid` in IDLE or FINISH is ignored and no byte is consumed.
- The word index never exceeds `Word_count`-1; no address wrap occurs.

## Timing
- Byte-to-write latency: 1 cycle after the 4th byte's handshake edge.
- Minimum load time: 4·`Word_count` + 2 cycles after `Start` acceptance, with `Byte_valid` held high.
- `Byte_ready` is combinational from state and counters. It has no combinational path from `Byte_valid`.
- `Write_enable`, `Write_address`, `Write_data`, `Cpu_hold`, `Done` and `Error` are registered.
- Reset asserted mid-load:
  - All outputs drop to 0 asynchronously.
  - The partial word is discarded.
  - Words already written are not rolled back.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - After the last instruction word, LOAD moves to CHECK.
  - CHECK accepts 4 more bytes, packed the same way, as an expected checksum.
  - The checksum is the sum mod 2^32 of all written words.
  - Match → FINISH with `Done`=1. Mismatch → IDLE with `Error`=1, `Done`=0.
  - The checksum word is never written to memory.
- Not defined:
  - No CHECK state, no accumulator.
  - `Error` is raised only by an invalid `Word_count`.

## Structure
- Shared package `imem_pkg`: `DEPTH`, `ADDR_W`, the loader state enum, byte-lane shift constants.
- One sub-module, `byte_packer`: it owns the byte counter, shift register and `word_valid` pulse. It is reused for the checksum word.

## Test plan
- `Word_count`=2; bytes 20 08 00 05 3C 01 10 00, `Byte_valid` held high → writes 0x20080005 to address 0 and 0x3C011000 to address 1; then `Done`=1 and `Cpu_hold`=0.
- Same stream with `Byte_valid` low on every other cycle → identical writes and address order; `Write_enable` pulses exactly twice, 1 cycle each.
- `Start` with `Word_count`=0, then again with 33 → no writes, `Error`=1 and `Byte_ready`=0 both times.
- `Word_count`=32 with an incrementing word pattern → 32 writes to addresses 0..31; `Byte_ready` drops after byte 128.
- `Reset_n` pulsed low after 6 bytes of a 3-word load → one write only (address 0); all outputs 0; a fresh `Start` reloads from address 0.
- With the macro, `Word_count`=1, word 0x00000001, checksum 0x00000001 → `Done`=1. With checksum 0x00000002 → `Error`=1, `Done`=0.
